decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction decode buffer between fetch and execute in the MIPS pipeline. It accepts fetched instruction/PC pairs over a valid/ready handshake and holds them in a DEPTH-entry FIFO. The head entry is decoded into a packed control bundle, which is registered into a single output stage. Flush support discards wrong-path instructions on branch redirect or exception.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- PC_W, 32, PC width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; equals (count < DEPTH), no combinational path from out_ready
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- flush  in  1  synchronous discard of all held instructions
- out_valid  out  1  decoded instruction present
- out_ready  in  1  execute consumes the output this cycle
- out_inst  out  32  registered instruction word
- out_pc  out  PC_W  registered PC
- out_ctrl  out  CTRL_W  registered control bundle (ctrl_pkg::ctrl_t)
- out_ri  out  1  reserved-instruction flag for out_inst
- count  out  $clog2(DEPTH)+1  FIFO occupancy, output stage excluded

## Operation
- Accept when in_valid && in_ready; pop out stage when out_valid && out_ready.
- Out stage loads when !out_valid or popping. Source: FIFO head if count>0; else the incoming accepted instruction (bypass, not written to FIFO).
- FIFO: circular, wr/rd pointers with wrap at DEPTH; simultaneous push and pop while partially full keeps count unchanged.
- Decode is purely combinational on the selected source.
- Control fields: regwrite, regdst (rd/rt/r31), alusrc, branch, bal, jump, jal, jr, jalr, memwrite[3:0] (SW 1111, SH 0011, SB 0001), memreadwidth[3:0] (LW 1111, LH/LHU 0011, LB/LBU 0001), load_signed (0 only for LBU/LHU), memtoreg, hilowrite, hi_from_reg, lo_from_reg, md_to_hilo, mul_not_div, md_signed (MULT/DIV only), hilo_to_reg, hilo_sel_hi, cp0_write, cp0_read, cp0_addr[4:0], syscall, brk, eret.
- regwrite set for ALU R-type, JALR, MFHI/MFLO, immediate ALU ops, loads, JAL, BGEZAL/BLTZAL, MFC0; never for branches, stores, JR, MT*, mult/div. regdst=r31 for JAL/BGEZAL/BLTZAL.
- regwrite forced 0 when resolved destination index is 0.
- Reserved instruction (any encoding outside the 57-instruction set): out_ri=1, all out_ctrl fields 0.

## Timing
- Reset: out_valid 0, out_inst 0, out_pc 0, out_ctrl 0, out_ri 0, count 0, pointers 0, in_ready 1.
- Latency: accept at edge N with empty FIFO and free out stage → out_valid at N+1.
- flush: at next edge FIFO emptied, out_valid 0; an accept in the flush cycle is discarded; flush beats push and pop.
- Full: in_ready 0 even if out stage pops that cycle; rises one cycle after count drops.
- out_* held stable while out_valid && !out_ready.
- Reset asserted mid-operation clears all state immediately.

## Configuration
- DECODE_CP0_EN defined: MFC0, MTC0, ERET decode; cp0_addr = rd field.
- Not defined: those encodings flag out_ri=1; cp0_write, cp0_read, eret, cp0_addr tied 0.

## Structure
- ctrl_pkg: ctrl_t packed struct, CTRL_W, opcode/funct/rt/rs constants, regdst encodings.
- Sub-module ctrl_decode: combinational inst → {ctrl_t, ri}; queue/handshake logic stays in decode_queue.

## Test plan
- Reset, then ADDIU $t0,$zero,5 (0x24080005) at pc 0xBFC00000 → out_valid next cycle, regwrite 1, alusrc imm, regdst rt, out_ri 0.
- Push 4 instructions with out_ready 0 (DEPTH 4) → out stage holds 1st, count 3, then 4 after 5th push, in_ready 0; release out_ready → in-order drain, pcs +4 each.
- ADDU $zero,$t1,$t2 (0x012A0021) → regwrite 0; BNE (0x15090003) → branch 1, regwrite 0.
- Flush with count 3 and simultaneous push → next cycle out_valid 0, count 0; pushed instruction never appears.
- SW (0xAD090004) memwrite 1111; LBU (0x91090000) memreadwidth 0001, load_signed 0, memtoreg 1.
- MFC0 $t0,$12 (0x40086000) → cp0_read 1, cp0_addr 12 with DECODE_CP0_EN; out_ri 1, ctrl 0 without; 0xFC000000 → out_ri 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle type, instruction field constants and destination-select
// encodings for the decode buffer.
package ctrl_pkg;

    localparam logic [1:0] REGDST_RD  = 2'd0;
    localparam logic [1:0] REGDST_RT  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       branch;
        logic       bal;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       jalr;
        logic [3:0] memwrite;
        logic [3:0] memreadwidth;
        logic       load_signed;
        logic       memtoreg;
        logic       hilowrite;
        logic       hi_from_reg;
        logic       lo_from_reg;
        logic       md_to_hilo;
        logic       mul_not_div;
        logic       md_signed;
        logic       hilo_to_reg;
        logic       hilo_sel_hi;
        logic       cp0_write;
        logic       cp0_read;
        logic [4:0] cp0_addr;
        logic       syscall;
        logic       brk;
        logic       eret;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    // REGIMM rt codes
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // COP0 rs codes and the single accepted ERET word
    localparam logic [4:0]  RS_MFC0   = 5'h00;
    localparam logic [4:0]  RS_MTC0   = 5'h04;
    localparam logic [31:0] INST_ERET = 32'h4200_0018;

    function automatic logic [4:0] dest_index(input logic [1:0] regdst,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
        case (regdst)
            REGDST_RD:  dest_index = rd;
            REGDST_RT:  dest_index = rt;
            REGDST_R31: dest_index = 5'd31;
            default:    dest_index = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder producing the control bundle and a
// reserved-instruction flag. COP0 instructions decode only with DECODE_CP0_EN.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        ri
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    ctrl_t      dec;
    logic       known;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign funct = inst[5:0];

    always_comb begin
        dec   = '0;
        known = 1'b1;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        dec.regwrite = 1'b1;
                        dec.regdst   = REGDST_RD;
                    end
                    FN_JR: begin
                        dec.jump = 1'b1;
                        dec.jr   = 1'b1;
                    end
                    FN_JALR: begin
                        dec.jump     = 1'b1;
                        dec.jr       = 1'b1;
                        dec.jalr     = 1'b1;
                        dec.regwrite = 1'b1;
                        dec.regdst   = REGDST_RD;
                    end
                    FN_SYSCALL: dec.syscall = 1'b1;
                    FN_BREAK:   dec.brk     = 1'b1;
                    FN_MFHI, FN_MFLO: begin
                        dec.regwrite    = 1'b1;
                        dec.regdst      = REGDST_RD;
                        dec.hilo_to_reg = 1'b1;
                        dec.hilo_sel_hi = (funct == FN_MFHI);
                    end
                    FN_MTHI: begin
                        dec.hilowrite   = 1'b1;
                        dec.hi_from_reg = 1'b1;
                    end
                    FN_MTLO: begin
                        dec.hilowrite   = 1'b1;
                        dec.lo_from_reg = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec.hilowrite   = 1'b1;
                        dec.md_to_hilo  = 1'b1;
                        dec.mul_not_div = (funct == FN_MULT) || (funct == FN_MULTU);
                        dec.md_signed   = (funct == FN_MULT) || (funct == FN_DIV);
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: dec.branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        dec.branch   = 1'b1;
                        dec.bal      = 1'b1;
                        dec.regwrite = 1'b1;
                        dec.regdst   = REGDST_R31;
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_J: dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump     = 1'b1;
                dec.jal      = 1'b1;
                dec.regwrite = 1'b1;
                dec.regdst   = REGDST_R31;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.regdst   = REGDST_RT;
                dec.alusrc   = 1'b1;
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                dec.regwrite    = 1'b1;
                dec.regdst      = REGDST_RT;
                dec.alusrc      = 1'b1;
                dec.memtoreg    = 1'b1;
                dec.load_signed = (op != OP_LBU) && (op != OP_LHU);
                dec.memreadwidth = (op == OP_LW) ? 4'b1111 :
                                   ((op == OP_LH) || (op == OP_LHU)) ? 4'b0011 : 4'b0001;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = (op == OP_SW) ? 4'b1111 :
                               (op == OP_SH) ? 4'b0011 : 4'b0001;
            end
`ifdef DECODE_CP0_EN
            OP_COP0: begin
                if (rs == RS_MFC0) begin
                    dec.regwrite = 1'b1;
                    dec.regdst   = REGDST_RT;
                    dec.cp0_read = 1'b1;
                    dec.cp0_addr = rd;
                end else if (rs == RS_MTC0) begin
                    dec.cp0_write = 1'b1;
                    dec.cp0_addr  = rd;
                end else if (inst == INST_ERET) begin
                    dec.eret = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
`else
            OP_COP0: known = 1'b0;
`endif
            default: known = 1'b0;
        endcase

        // Writes to $zero are architecturally dropped; suppress them here.
        if (dest_index(dec.regdst, rt, rd) == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    assign ctrl = known ? dec : '0;
    assign ri   = !known;

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-execute decode buffer: DEPTH-entry FIFO plus one registered decode
// output stage with flush. COP0 decode is enabled by defining DECODE_CP0_EN.
module decode_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_W-1:0]            out_pc,
    output ctrl_t                      out_ctrl,
    output logic                       out_ri,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      inst_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             out_valid_reg;
    logic [31:0]      out_inst_reg;
    logic [PC_W-1:0]  out_pc_reg;
    ctrl_t            out_ctrl_reg;
    logic             out_ri_reg;

    logic             accept;
    logic             pop_out;
    logic             load_out;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             bypass;
    logic             fifo_push;
    logic [31:0]      sel_inst;
    logic [PC_W-1:0]  sel_pc;
    ctrl_t            dec_ctrl;
    logic             dec_ri;

    assign fifo_empty = (count_reg == '0);
    // Ready depends only on occupancy, so a full queue stays closed even while
    // the output stage drains.
    assign in_ready   = (count_reg < CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign pop_out    = out_valid_reg && out_ready;
    assign load_out   = !out_valid_reg || pop_out;
    assign fifo_pop   = load_out && !fifo_empty;
    assign bypass     = load_out && fifo_empty && accept;
    assign fifo_push  = accept && !bypass && !flush;

    assign sel_inst = fifo_empty ? in_inst : inst_mem[rd_ptr_reg];
    assign sel_pc   = fifo_empty ? in_pc   : pc_mem[rd_ptr_reg];

    ctrl_decode u_ctrl_decode (
        .inst (sel_inst),
        .ctrl (dec_ctrl),
        .ri   (dec_ri)
    );

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            inst_mem[wr_ptr_reg] <= in_inst;
            pc_mem[wr_ptr_reg]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_pc_reg    <= '0;
            out_ctrl_reg  <= '0;
            out_ri_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                count_reg <= count_reg - 1'b1;
            end

            if (fifo_pop || bypass) begin
                out_valid_reg <= 1'b1;
                out_inst_reg  <= sel_inst;
                out_pc_reg    <= sel_pc;
                out_ctrl_reg  <= dec_ctrl;
                out_ri_reg    <= dec_ri;
            end else if (load_out) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_inst  = out_inst_reg;
    assign out_pc    = out_pc_reg;
    assign out_ctrl  = out_ctrl_reg;
    assign out_ri    = out_ri_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH 4); MFC0 expectations
// follow DECODE_CP0_EN.
module tb_decode_queue;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    ctrl_t       out_ctrl;
    logic        out_ri;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_ri    (out_ri),
        .count     (count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick; tick;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_ri", out_ri, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        resetn = 1'b1;

        // ADDIU $t0,$zero,5 bypasses straight into the output stage
        in_valid = 1'b1; in_inst = 32'h24080005; in_pc = 32'hBFC00000;
        tick;
        in_valid = 1'b0;
        check("addiu_valid", out_valid, 1);
        check("addiu_inst", out_inst, 32'h24080005);
        check("addiu_pc", out_pc, 32'hBFC00000);
        check("addiu_regwrite", out_ctrl.regwrite, 1);
        check("addiu_alusrc", out_ctrl.alusrc, 1);
        check("addiu_regdst", out_ctrl.regdst, REGDST_RT);
        check("addiu_ri", out_ri, 0);
        check("addiu_count", count, 0);
        tick;
        check("hold_valid", out_valid, 1);
        check("hold_pc", out_pc, 32'hBFC00000);
        out_ready = 1'b1;
        tick;
        check("drain_valid", out_valid, 0);

        // Fill: out stage + 4 FIFO entries while execute stalls
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h24080000 | 32'(k); in_pc = 32'h100 + 32'(4 * k);
            tick;
        end
        check("fill_count3", count, 3);
        check("fill_head_pc", out_pc, 32'h100);
        in_inst = 32'h24080004; in_pc = 32'h110;
        tick;
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_hold_pc", out_pc, 32'h100);
        // Sixth offer while full and popping must be refused
        in_inst = 32'h24081234; in_pc = 32'h2000; out_ready = 1'b1;
        check("full_pop_in_ready", in_ready, 0);
        tick;
        in_valid = 1'b0;
        check("after_pop_count", count, 3);
        check("after_pop_in_ready", in_ready, 1);
        check("drain_pc1", out_pc, 32'h104);
        for (int k = 2; k < 5; k++) begin
            tick;
            check("drain_pc", out_pc, 32'h100 + 64'(4 * k));
            check("drain_inst", out_inst, 32'h24080000 | 64'(k));
        end
        check("drained_count", count, 0);
        tick;
        check("drained_valid", out_valid, 0);

        // ADDU to $zero, then BNE loaded while the stage pops
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h012A0021; in_pc = 32'h200;
        tick;
        check("addu_valid", out_valid, 1);
        check("addu_regwrite", out_ctrl.regwrite, 0);
        check("addu_ri", out_ri, 0);
        out_ready = 1'b1; in_inst = 32'h15090003; in_pc = 32'h204;
        tick;
        in_valid = 1'b0;
        check("bne_pc", out_pc, 32'h204);
        check("bne_branch", out_ctrl.branch, 1);
        check("bne_regwrite", out_ctrl.regwrite, 0);
        check("bne_count", count, 0);
        tick;
        check("bne_drained", out_valid, 0);

        // Flush with count 3 and a simultaneous push
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h24090000 | 32'(k); in_pc = 32'h300 + 32'(4 * k);
            tick;
        end
        check("preflush_count", count, 3);
        flush = 1'b1; in_inst = 32'h24090007; in_pc = 32'hDEAD0000;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_count", count, 0);
        out_ready = 1'b1;
        tick;
        check("flush_discard", out_valid, 0);

        // Memory and jump decode, streaming one per cycle
        in_valid = 1'b1; in_inst = 32'hAD090004; in_pc = 32'h400;
        tick;
        check("sw_pc", out_pc, 32'h400);
        check("sw_memwrite", out_ctrl.memwrite, 4'b1111);
        check("sw_regwrite", out_ctrl.regwrite, 0);
        in_inst = 32'h91090000; in_pc = 32'h404;
        tick;
        check("lbu_pc", out_pc, 32'h404);
        check("lbu_width", out_ctrl.memreadwidth, 4'b0001);
        check("lbu_signed", out_ctrl.load_signed, 0);
        check("lbu_memtoreg", out_ctrl.memtoreg, 1);
        check("lbu_regwrite", out_ctrl.regwrite, 1);
        in_inst = 32'h0C000010; in_pc = 32'h408;
        tick;
        check("jal_jal", out_ctrl.jal, 1);
        check("jal_regdst", out_ctrl.regdst, REGDST_R31);
        check("jal_regwrite", out_ctrl.regwrite, 1);
        in_inst = 32'h40086000; in_pc = 32'h40C;
        tick;
        check("mfc0_pc", out_pc, 32'h40C);
`ifdef DECODE_CP0_EN
        check("mfc0_ri", out_ri, 0);
        check("mfc0_cp0_read", out_ctrl.cp0_read, 1);
        check("mfc0_cp0_addr", out_ctrl.cp0_addr, 12);
        check("mfc0_regwrite", out_ctrl.regwrite, 1);
`else
        check("mfc0_ri", out_ri, 1);
        check("mfc0_ctrl", out_ctrl, 0);
`endif
        in_inst = 32'hFC000000; in_pc = 32'h410;
        tick;
        in_valid = 1'b0;
        check("resv_ri", out_ri, 1);
        check("resv_ctrl", out_ctrl, 0);
        tick;
        check("stream_end_valid", out_valid, 0);

        // Asynchronous reset in mid-cycle
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h24080001; in_pc = 32'h500;
        tick;
        in_pc = 32'h504;
        tick;
        in_valid = 1'b0;
        check("prereset_count", count, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_pc", out_pc, 0);
        tick;
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
